instruction_fetch: RTL and testbench
====================================

Name: instruction_fetch

Overview:
- PC register and fetch stage of the core, directly upstream of the next-address calculator.
- Holds the word-addressed PC and drives it to the calculator as pc_out; loads the calculator's next_address when an instruction is accepted.
- Runs a request/acknowledge handshake with instruction memory.
- Delivers instruction plus PC to the decode stage through an IF/ID register with stall and flush support.

Parameters:
- ADDR_W, 32, PC / memory address width (word addresses; sequential PC increments by 1).
- DATA_W, 32, instruction width.
- RESET_VECTOR, 0, PC value after reset.

Ports:
- clock  in  1  single system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- next_address  in  ADDR_W  PC to load, from the next-address calculator.
- pc_out  out  ADDR_W  current PC, to the next-address calculator (pc_in) and to imem.
- imem_req  out  1  fetch request; held high until acknowledged.
- imem_addr  out  ADDR_W  fetch address; equals pc_out while imem_req is high.
- imem_ack  in  1  memory response valid; one cycle per request; latency 1..N cycles after the request is first asserted.
- imem_data  in  DATA_W  instruction word; valid only with imem_ack.
- stall  in  1  decode cannot accept; hold the IF/ID register.
- flush  in  1  branch/jump redirect; next_address carries the target.
- if_instr  out  DATA_W  IF/ID instruction.
- if_pc  out  ADDR_W  IF/ID PC of if_instr.
- if_valid  out  1  IF/ID contents valid.

Behaviour:
- Reset asserted (reset=0), asynchronous:
  - PC = RESET_VECTOR.
  - State = IDLE.
  - imem_req=0, if_valid=0, if_instr=0, if_pc=0.
  - drop flag = 0, hold register = 0.
- FSM states:
  - IDLE: one cycle after reset release; then goes to FETCH.
  - FETCH: imem_req=1, imem_addr=PC; waits for ack.
  - HOLD: instruction captured but decode is stalled; imem_req=0.
- FETCH with ack, drop=0, flush=0, stall=0:
  - if_instr←imem_data, if_pc←PC, if_valid←1.
  - PC←next_address.
  - Stay in FETCH; the next request issues with the new PC the following cycle (back-to-back fetch, one instruction per ack).
- FETCH with ack, stall=1, flush=0:
  - imem_data goes into the hold register; go to HOLD.
  - IF/ID and PC are unchanged.
- HOLD:
  - While stall=1, all outputs are held.
  - When stall=0: if_instr←hold, if_pc←PC, if_valid←1, PC←next_address, go to FETCH.
- FETCH, no ack, stall=1: if_valid and IF/ID are held; the request stays outstanding.
- Flush (any state; priority flush > stall > normal):
  - if_valid←0 and PC←next_address in the same edge.
  - HOLD→FETCH; the hold register is discarded.
  - FETCH with request outstanding and no ack that cycle: set drop=1.
  - FETCH with ack in the same cycle: discard data, re-request from the new PC; drop stays 0.
- Dropped response: on ack with drop=1, discard data, clear drop, re-request from the current PC. If_valid is not set and PC is unchanged, unless a flush coincides; then flush rules apply and drop stays 1 only if another request is outstanding. It is not.
- imem_addr must not change while imem_req=1 and ack is pending. A flush updates PC, but imem_addr is registered from the pending request until ack.
- PC arithmetic belongs to the calculator. This block never adds; PC wraps only as next_address wraps.
- Reset mid-request: the outstanding ack after reset is ignored, because IDLE does not sample ack.

Optional Feature:
- IFETCH_PERF_EN:
  - When defined, adds outputs stall_cycles[31:0] and flush_count[31:0].
  - stall_cycles counts clocks with imem_req=1 and no ack, plus clocks in HOLD.
  - flush_count counts accepted flushes.
  - Both saturate at all-ones and reset to 0.
  - When undefined, no ports and no logic.

Decomposition:
- Shared package musa_pkg: ADDR_W/DATA_W defaults, RESET_VECTOR, FSM state encoding (IDLE=2'd0, FETCH=2'd1, HOLD=2'd2).
- One natural sub-module: if_id_reg. It holds the IF/ID register with load/hold/clear controls, and is reused by the decode stage's own pipeline register.

Test Plan:
- Reset release, ack latency 1, next_address=pc+1 → imem_addr 0,1,2…; if_pc 0,1,2 with matching if_instr; if_valid=1 from the third cycle after release.
- Ack latency 3 cycles → imem_req held, imem_addr stable at 5 for 3 cycles; if_valid holds the previous entry; no PC change.
- Ack at PC=7 with stall=1 for 4 cycles → HOLD, outputs frozen; stall drop → if_pc=7, PC=8 next edge.
- Flush with target 0x40 while request for 0x10 is outstanding → if_valid=0; the 0x10 ack is discarded; next imem_addr=0x40; if_pc=0x40 is delivered.
- Flush and stall in the same cycle as ack → flush wins: if_valid=0, PC=target, no HOLD entry.
- Reset asserted mid-request with ack arriving one cycle after release → ack ignored; first fetched address = RESET_VECTOR.

Source files
------------

// File: rtl/musa_pkg.sv
// Shared core definitions: default widths, reset vector and fetch FSM encoding.
package musa_pkg;

  localparam int unsigned MUSA_ADDR_W       = 32;
  localparam int unsigned MUSA_DATA_W       = 32;
  localparam logic [31:0] MUSA_RESET_VECTOR = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/instruction_fetch_if.sv
// Instruction-memory request/acknowledge bus between the fetch stage and imem.
interface instruction_fetch_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);

  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [DATA_W-1:0] imem_data;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_data
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_data
  );

endinterface

// File: rtl/if_id_reg.sv
// Pipeline register carrying instruction + PC with load/hold/clear; clear only drops valid.
module if_id_reg
  import musa_pkg::*;
#(
  parameter int unsigned ADDR_W = MUSA_ADDR_W,
  parameter int unsigned DATA_W = MUSA_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic              clear_i,
  input  logic [DATA_W-1:0] instr_i,
  input  logic [ADDR_W-1:0] pc_i,
  output logic [DATA_W-1:0] instr_o,
  output logic [ADDR_W-1:0] pc_o,
  output logic              valid_o
);

  logic [DATA_W-1:0] instr_q;
  logic [ADDR_W-1:0] pc_q;
  logic              valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q <= '0;
      pc_q    <= '0;
      valid_q <= 1'b0;
    end else if (clear_i) begin
      valid_q <= 1'b0;
    end else if (load_i) begin
      instr_q <= instr_i;
      pc_q    <= pc_i;
      valid_q <= 1'b1;
    end
  end

  assign instr_o = instr_q;
  assign pc_o    = pc_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/instruction_fetch.sv
// PC register and fetch stage: imem handshake, IF/ID delivery with stall/flush.
// Optional IFETCH_PERF_EN adds saturating stall_cycles / flush_count outputs.
module instruction_fetch
  import musa_pkg::*;
#(
  parameter int unsigned       ADDR_W       = MUSA_ADDR_W,
  parameter int unsigned       DATA_W       = MUSA_DATA_W,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = ADDR_W'(MUSA_RESET_VECTOR)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   next_address,
  output logic [ADDR_W-1:0]   pc_out,
  instruction_fetch_if.master imem,
  input  logic                stall,
  input  logic                flush,
  output logic [DATA_W-1:0]   if_instr,
  output logic [ADDR_W-1:0]   if_pc,
  output logic                if_valid
`ifdef IFETCH_PERF_EN
  ,
  output logic [31:0]         stall_cycles,
  output logic [31:0]         flush_count
`endif
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              drop_q, drop_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic [DATA_W-1:0] ld_instr;
  logic              ifid_load;
  logic              ifid_clear;
  logic              new_req;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      pc_q    <= RESET_VECTOR;
      addr_q  <= RESET_VECTOR;
      drop_q  <= 1'b0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      drop_q  <= drop_d;
      hold_q  <= hold_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    addr_d     = addr_q;
    drop_d     = drop_q;
    hold_d     = hold_q;
    ld_instr   = imem.imem_data;
    ifid_load  = 1'b0;
    ifid_clear = 1'b0;
    new_req    = 1'b0;

    unique case (state_q)
      IDLE: begin
        // ack is deliberately not looked at here: it may belong to a pre-reset request
        state_d = FETCH;
        new_req = 1'b1;
        if (flush) begin
          ifid_clear = 1'b1;
          pc_d       = next_address;
        end
      end

      FETCH: begin
        if (flush) begin
          ifid_clear = 1'b1;
          pc_d       = next_address;
          if (imem.imem_ack) begin
            drop_d  = 1'b0;
            new_req = 1'b1;
          end else begin
            drop_d  = 1'b1;
          end
        end else if (imem.imem_ack && drop_q) begin
          drop_d  = 1'b0;
          new_req = 1'b1;
        end else if (imem.imem_ack && stall) begin
          hold_d  = imem.imem_data;
          state_d = HOLD;
        end else if (imem.imem_ack) begin
          ifid_load = 1'b1;
          pc_d      = next_address;
          new_req   = 1'b1;
        end
      end

      HOLD: begin
        if (flush) begin
          ifid_clear = 1'b1;
          pc_d       = next_address;
          hold_d     = '0;
          state_d    = FETCH;
          new_req    = 1'b1;
        end else if (!stall) begin
          ld_instr  = hold_q;
          ifid_load = 1'b1;
          pc_d      = next_address;
          state_d   = FETCH;
          new_req   = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // The request address is latched only when a new request starts, so a
    // flush against a pending request leaves imem_addr stable until its ack.
    if (new_req) begin
      addr_d = pc_d;
    end
  end

  assign imem.imem_req  = (state_q == FETCH);
  assign imem.imem_addr = addr_q;
  assign pc_out         = pc_q;

  if_id_reg #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_if_id_reg (
    .clk     (clock),
    .rst_n   (reset),
    .load_i  (ifid_load),
    .clear_i (ifid_clear),
    .instr_i (ld_instr),
    .pc_i    (pc_q),
    .instr_o (if_instr),
    .pc_o    (if_pc),
    .valid_o (if_valid)
  );

`ifdef IFETCH_PERF_EN
  logic [31:0] stall_cycles_q;
  logic [31:0] flush_count_q;
  logic        stall_tick;

  assign stall_tick = ((state_q == FETCH) && !imem.imem_ack) || (state_q == HOLD);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      if (stall_tick && (stall_cycles_q != '1)) begin
        stall_cycles_q <= stall_cycles_q + 32'd1;
      end
      if (flush && (flush_count_q != '1)) begin
        flush_count_q <= flush_count_q + 32'd1;
      end
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_count  = flush_count_q;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: per-cycle vector table plus flush/reset sequences.
module tb_instruction_fetch;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic          clock = 1'b0;
  logic          reset;
  logic [AW-1:0] next_address;
  logic [AW-1:0] pc_out;
  logic          stall;
  logic          flush;
  logic [DW-1:0] if_instr;
  logic [AW-1:0] if_pc;
  logic          if_valid;
`ifdef IFETCH_PERF_EN
  logic [31:0]   stall_cycles;
  logic [31:0]   flush_count;
`endif

  // Upstream calculator stand-in: sequential successor unless a target is forced.
  logic          use_tgt;
  logic [AW-1:0] tgt;
  assign next_address = use_tgt ? tgt : pc_out + 32'd1;

  instruction_fetch_if #(.ADDR_W(AW), .DATA_W(DW)) imem ();

  instruction_fetch #(
    .ADDR_W       (AW),
    .DATA_W       (DW),
    .RESET_VECTOR (32'h0000_0000)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .next_address (next_address),
    .pc_out       (pc_out),
    .imem         (imem.master),
    .stall        (stall),
    .flush        (flush),
    .if_instr     (if_instr),
    .if_pc        (if_pc),
    .if_valid     (if_valid)
`ifdef IFETCH_PERF_EN
    ,
    .stall_cycles (stall_cycles),
    .flush_count  (flush_count)
`endif
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int lat    = 1;
  int cnt    = 0;
  bit mem_en = 1'b1;

  typedef struct {
    logic          stall;
    int            lat;
    logic          req;
    logic [AW-1:0] addr;
    logic          valid;
    logic [AW-1:0] ifpc;
    logic [AW-1:0] pc;
  } vec_t;

  vec_t tbl[25];

  function automatic logic [DW-1:0] instr_of(input logic [AW-1:0] a);
    return {16'hC0DE, a[15:0]};
  endfunction

  function automatic vec_t mk(input logic s, input int l, input logic rq,
                              input logic [AW-1:0] ad, input logic v,
                              input logic [AW-1:0] ip, input logic [AW-1:0] p);
    vec_t r;
    r.stall = s; r.lat = l; r.req = rq; r.addr = ad; r.valid = v; r.ifpc = ip; r.pc = p;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic rq, input logic [AW-1:0] ad,
                            input logic v, input logic [AW-1:0] ip, input logic [AW-1:0] p);
    check({tag, " imem_req"}, 32'(imem.imem_req), 32'(rq));
    if (rq) check({tag, " imem_addr"}, imem.imem_addr, ad);
    check({tag, " if_valid"}, 32'(if_valid), 32'(v));
    if (v) begin
      check({tag, " if_pc"}, if_pc, ip);
      check({tag, " if_instr"}, if_instr, instr_of(ip));
    end
    check({tag, " pc_out"}, pc_out, p);
  endtask

  // One clock: imem model samples the pre-edge bus, answers #1 after the edge,
  // and the caller checks at the following falling edge.
  task automatic tick();
    logic          r, a;
    logic [AW-1:0] ad;
    r  = imem.imem_req;
    a  = imem.imem_ack;
    ad = imem.imem_addr;
    @(posedge clock);
    #1;
    if (mem_en) begin
      if (a) begin
        imem.imem_ack = 1'b0;
        cnt = 0;
      end else if (r) begin
        cnt++;
        if (cnt >= lat) begin
          imem.imem_ack  = 1'b1;
          imem.imem_data = instr_of(ad);
        end
      end
    end
    @(negedge clock);
  endtask

  task automatic stp(input logic s, input logic f, input logic [AW-1:0] t);
    stall   = s;
    flush   = f;
    use_tgt = f;
    tgt     = t;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    reset          = 1'b0;
    stall          = 1'b0;
    flush          = 1'b0;
    use_tgt        = 1'b0;
    tgt            = '0;
    imem.imem_ack  = 1'b0;
    imem.imem_data = '0;

    //             stall lat req addr v  if_pc pc
    tbl[0]  = mk(0, 1, 1, 0, 0, 0, 0);
    tbl[1]  = mk(0, 1, 1, 0, 0, 0, 0);
    tbl[2]  = mk(0, 1, 1, 1, 1, 0, 1);
    tbl[3]  = mk(0, 1, 1, 1, 1, 0, 1);
    tbl[4]  = mk(0, 1, 1, 2, 1, 1, 2);
    tbl[5]  = mk(0, 1, 1, 2, 1, 1, 2);
    tbl[6]  = mk(0, 1, 1, 3, 1, 2, 3);
    tbl[7]  = mk(0, 1, 1, 3, 1, 2, 3);
    tbl[8]  = mk(0, 1, 1, 4, 1, 3, 4);
    tbl[9]  = mk(0, 1, 1, 4, 1, 3, 4);
    tbl[10] = mk(0, 1, 1, 5, 1, 4, 5);
    tbl[11] = mk(0, 3, 1, 5, 1, 4, 5);
    tbl[12] = mk(0, 3, 1, 5, 1, 4, 5);
    tbl[13] = mk(0, 3, 1, 5, 1, 4, 5);
    tbl[14] = mk(0, 3, 1, 6, 1, 5, 6);
    tbl[15] = mk(0, 1, 1, 6, 1, 5, 6);
    tbl[16] = mk(0, 1, 1, 7, 1, 6, 7);
    tbl[17] = mk(0, 1, 1, 7, 1, 6, 7);
    tbl[18] = mk(1, 1, 0, 7, 1, 6, 7);
    tbl[19] = mk(1, 1, 0, 7, 1, 6, 7);
    tbl[20] = mk(1, 1, 0, 7, 1, 6, 7);
    tbl[21] = mk(1, 1, 0, 7, 1, 6, 7);
    tbl[22] = mk(0, 1, 1, 8, 1, 7, 8);
    tbl[23] = mk(1, 1, 1, 8, 1, 7, 8);
    tbl[24] = mk(0, 1, 1, 9, 1, 8, 9);

    repeat (3) @(negedge clock);
    expect_out("reset", 1'b0, '0, 1'b0, '0, 32'h0);
    check("reset if_pc", if_pc, 32'h0);
    check("reset if_instr", if_instr, 32'h0);

    reset = 1'b1;
    for (int unsigned i = 0; i < 25; i++) begin
      stall = tbl[i].stall;
      lat   = tbl[i].lat;
      tick();
      expect_out($sformatf("vec%0d", i), tbl[i].req, tbl[i].addr, tbl[i].valid,
                 tbl[i].ifpc, tbl[i].pc);
    end

    // Flush while the request for 9 is pending, then redirect 0x10 -> 0x40.
    lat = 3;
    stp(0, 1, 32'h10); expect_out("flush10",    1, 32'h09, 0, 0, 32'h10);
    stp(0, 0, 0);      expect_out("pend9a",     1, 32'h09, 0, 0, 32'h10);
    stp(0, 0, 0);      expect_out("pend9b",     1, 32'h09, 0, 0, 32'h10);
    stp(0, 0, 0);      expect_out("drop9",      1, 32'h10, 0, 0, 32'h10);
    lat = 2;
    stp(0, 1, 32'h40); expect_out("flush40",    1, 32'h10, 0, 0, 32'h40);
    stp(0, 0, 0);      expect_out("ack10",      1, 32'h10, 0, 0, 32'h40);
    stp(0, 0, 0);      expect_out("drop10",     1, 32'h40, 0, 0, 32'h40);
    stp(0, 0, 0);      expect_out("wait40a",    1, 32'h40, 0, 0, 32'h40);
    stp(0, 0, 0);      expect_out("wait40b",    1, 32'h40, 0, 0, 32'h40);
    stp(0, 0, 0);      expect_out("got40",      1, 32'h41, 1, 32'h40, 32'h41);

    // Flush and stall together with an ack: flush wins, no HOLD.
    lat = 1;
    stp(0, 0, 0);      expect_out("ack41",      1, 32'h41, 1, 32'h40, 32'h41);
    stp(1, 1, 32'h80); expect_out("flushstall", 1, 32'h80, 0, 0, 32'h80);
    stp(0, 0, 0);      expect_out("wait80",     1, 32'h80, 0, 0, 32'h80);
    stp(0, 0, 0);      expect_out("got80",      1, 32'h81, 1, 32'h80, 32'h81);

    // Reset mid-request; a stray ack right after release must be ignored.
    mem_en = 1'b0;
    reset  = 1'b0;
    #1;
    expect_out("async_rst", 1'b0, '0, 1'b0, '0, 32'h0);
    @(negedge clock);
    reset          = 1'b1;
    imem.imem_ack  = 1'b1;
    imem.imem_data = 32'hDEAD_BEEF;
    stp(0, 0, 0);      expect_out("rst_idle",   1, 32'h00, 0, 0, 32'h00);
    imem.imem_ack = 1'b0;
    cnt    = 0;
    lat    = 1;
    mem_en = 1'b1;
    stp(0, 0, 0);      expect_out("rst_wait",   1, 32'h00, 0, 0, 32'h00);
    stp(0, 0, 0);      expect_out("rst_first",  1, 32'h01, 1, 32'h00, 32'h01);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
